// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, one outstanding imem read, FIFO_DEPTH-entry instruction buffer.
// Latency: a word acked at edge N is at the buffer head (instr_valid=1) from edge N.
// Backpressure: a new request issues only while the buffer will have room; redirects flush it.
// IFU_ALIGN_CHECK_EN: misaligned redirect sets sticky align_err and halts fetch.

module ifu_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop_rdy,
    output logic                   head_vld,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign pop      = pop_rdy & head_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_vld) - CW'(pop);
        end
    end
endmodule

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        align_err
);
    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HALT} state_t;

    state_t        state, state_d;
    logic [31:0]   fetch_pc, pc_d, addr_d, tgt_pc;
    logic          req_d, push, pop, flush, xfer, waiting;
    logic          misalign, halt_pend, halt_pend_d;
    logic [CW-1:0] count, count_next;
    logic [63:0]   head_dat;

    assign xfer    = imem_req & imem_ack;
    assign waiting = imem_req & ~imem_ack;
    assign pop     = instr_valid & instr_ready;
    assign tgt_pc  = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_ALIGN_CHECK_EN
    assign misalign = redirect & (state != S_HALT) & (redirect_pc[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    if (waiting)       state_d = S_DISCARD;
                    else if (misalign) state_d = S_HALT;
                end
            end
            // imem_req is always high here: the stale response is still owed
            S_DISCARD: if (imem_ack) state_d = halt_pend_d ? S_HALT : S_FETCH;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        push        = 1'b0;
        flush       = 1'b0;
        pc_d        = fetch_pc;
        req_d       = imem_req;
        addr_d      = imem_addr;
        halt_pend_d = halt_pend | misalign;
        count_next  = count;
        case (state)
            S_FETCH: begin
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = tgt_pc;
                    if (!waiting) begin
                        req_d  = ~misalign;
                        addr_d = tgt_pc;
                    end
                end else begin
                    push = xfer;
                    if (xfer) pc_d = fetch_pc + 32'd4;
                    count_next = count + CW'(push) - CW'(pop);
                    if (!waiting) begin
                        req_d  = (count_next < DEPTH_C);
                        addr_d = pc_d;
                    end
                end
            end
            S_DISCARD: begin
                flush = redirect;
                if (redirect) pc_d = tgt_pc;
                if (imem_ack) begin
                    req_d  = ~halt_pend_d;
                    addr_d = pc_d;
                end
            end
            default: begin
                flush = 1'b1;
                req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            halt_pend <= 1'b0;
        end else begin
            fetch_pc  <= pc_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            halt_pend <= halt_pend_d;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) align_err <= 1'b0;
        else        align_err <= align_err | misalign;
    end
`else
    assign align_err = 1'b0;
`endif

    ifu_fifo #(.W(64), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (reset),
        .flush    (flush),
        .push_vld (push),
        .push_dat ({imem_addr, imem_rdata}),
        .pop_rdy  (pop),
        .head_vld (instr_valid),
        .head_dat (head_dat),
        .count    (count)
    );

    assign instr_pc = head_dat[63:32];
    assign instr    = head_dat[31:0];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed cycle-vector bench for instruction_fetch_unit plus reset / fill / pop sequences.
module tb_instruction_fetch_unit;
`ifdef IFU_ALIGN_CHECK_EN
    localparam logic A = 1'b1;
`else
    localparam logic A = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        align_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .align_err   (align_err)
    );

    typedef struct {
        logic        ack;
        logic        rdy;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_aerr;
    } vec_t;

    localparam int NV = 28;
    vec_t tv [NV];

    function automatic vec_t mk(input logic ack, input logic rdy, input logic [31:0] rdata,
                                input logic redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_vld, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic e_aerr);
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.rdata = rdata; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pc = e_pc;
        v.e_instr = e_instr; v.e_aerr = e_aerr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    int xfers;

    initial begin
        // ack rdy rdata redir rpc | req addr vld pc instr aerr
        tv[0]  = mk(0, 1, 32'h0,         0, 32'h0,        1,  32'h0,        0,  32'h0,        32'h0,        0);
        tv[1]  = mk(1, 1, 32'h1000_0000, 0, 32'h0,        1,  32'h4,        1,  32'h0,        32'h1000_0000, 0);
        tv[2]  = mk(1, 1, 32'h1000_0004, 0, 32'h0,        1,  32'h8,        1,  32'h4,        32'h1000_0004, 0);
        tv[3]  = mk(1, 1, 32'h1000_0008, 0, 32'h0,        1,  32'hC,        1,  32'h8,        32'h1000_0008, 0);
        tv[4]  = mk(1, 0, 32'h1000_000C, 0, 32'h0,        1,  32'h10,       1,  32'h8,        32'h1000_0008, 0);
        tv[5]  = mk(1, 0, 32'h1000_0010, 0, 32'h0,        1,  32'h14,       1,  32'h8,        32'h1000_0008, 0);
        tv[6]  = mk(1, 0, 32'h1000_0014, 0, 32'h0,        0,  32'h0,        1,  32'h8,        32'h1000_0008, 0);
        tv[7]  = mk(1, 0, 32'h0BAD_0000, 0, 32'h0,        0,  32'h0,        1,  32'h8,        32'h1000_0008, 0);
        tv[8]  = mk(0, 1, 32'h0BAD_0001, 0, 32'h0,        1,  32'h18,       1,  32'hC,        32'h1000_000C, 0);
        tv[9]  = mk(0, 0, 32'h0BAD_0001, 0, 32'h0,        1,  32'h18,       1,  32'hC,        32'h1000_000C, 0);
        tv[10] = mk(0, 0, 32'h0BAD_0001, 0, 32'h0,        1,  32'h18,       1,  32'hC,        32'h1000_000C, 0);
        tv[11] = mk(0, 0, 32'h0BAD_0001, 0, 32'h0,        1,  32'h18,       1,  32'hC,        32'h1000_000C, 0);
        tv[12] = mk(1, 0, 32'h1000_0018, 0, 32'h0,        0,  32'h0,        1,  32'hC,        32'h1000_000C, 0);
        tv[13] = mk(0, 1, 32'h0,         0, 32'h0,        1,  32'h1C,       1,  32'h10,       32'h1000_0010, 0);
        tv[14] = mk(0, 1, 32'h0,         0, 32'h0,        1,  32'h1C,       1,  32'h14,       32'h1000_0014, 0);
        tv[15] = mk(0, 1, 32'h0,         0, 32'h0,        1,  32'h1C,       1,  32'h18,       32'h1000_0018, 0);
        tv[16] = mk(0, 1, 32'h0,         0, 32'h0,        1,  32'h1C,       0,  32'h0,        32'h0,        0);
        tv[17] = mk(0, 0, 32'h0,         1, 32'h100,      1,  32'h1C,       0,  32'h0,        32'h0,        0);
        tv[18] = mk(1, 0, 32'hDEAD_BEEF, 0, 32'h0,        1,  32'h100,      0,  32'h0,        32'h0,        0);
        tv[19] = mk(1, 0, 32'h2000_0100, 0, 32'h0,        1,  32'h104,      1,  32'h100,      32'h2000_0100, 0);
        tv[20] = mk(0, 1, 32'h0,         0, 32'h0,        1,  32'h104,      0,  32'h0,        32'h0,        0);
        tv[21] = mk(1, 0, 32'h2000_0104, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8, 0, 32'h0,        32'h0,        0);
        tv[22] = mk(1, 1, 32'h3000_0000, 0, 32'h0,        1,  32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h3000_0000, 0);
        tv[23] = mk(1, 1, 32'h3000_0001, 0, 32'h0,        1,  32'h0,        1,  32'hFFFF_FFFC, 32'h3000_0001, 0);
        tv[24] = mk(0, 1, 32'h0,         1, 32'h102,      1,  32'h0,        0,  32'h0,        32'h0,        A);
        tv[25] = mk(1, 0, 32'hBADB_AD00, 0, 32'h0,        !A, 32'h100,      0,  32'h0,        32'h0,        A);
        tv[26] = mk(1, 0, 32'h4000_0100, 0, 32'h0,        !A, 32'h104,      !A, 32'h100,      32'h4000_0100, A);
        tv[27] = mk(0, 0, 32'h0,         1, 32'h200,      !A, 32'h104,      0,  32'h0,        32'h0,        A);

        reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   0, 32'(imem_req),    32'h0);
        chk("rst_addr",  0, imem_addr,        32'h0);
        chk("rst_vld",   0, 32'(instr_valid), 32'h0);
        chk("rst_instr", 0, instr,            32'h0);
        chk("rst_pc",    0, instr_pc,         32'h0);
        chk("rst_aerr",  0, 32'(align_err),   32'h0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            imem_ack    = tv[i].ack;
            instr_ready = tv[i].rdy;
            imem_rdata  = tv[i].rdata;
            redirect    = tv[i].redir;
            redirect_pc = tv[i].rpc;
            @(posedge clk);
            #1;
            chk("req", i, 32'(imem_req), 32'(tv[i].e_req));
            if (tv[i].e_req) chk("addr", i, imem_addr, tv[i].e_addr);
            chk("vld", i, 32'(instr_valid), 32'(tv[i].e_vld));
            if (tv[i].e_vld) begin
                chk("pc",    i, instr_pc, tv[i].e_pc);
                chk("instr", i, instr,    tv[i].e_instr);
            end
            chk("aerr", i, 32'(align_err), 32'(tv[i].e_aerr));
        end

        // asynchronous reset while a request is outstanding
        redirect = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req",   0, 32'(imem_req),    32'h0);
        chk("mid_rst_addr",  0, imem_addr,        32'h0);
        chk("mid_rst_vld",   0, 32'(instr_valid), 32'h0);
        chk("mid_rst_instr", 0, instr,            32'h0);
        chk("mid_rst_aerr",  0, 32'(align_err),   32'h0);

        // fill from empty with instr_ready low: exactly FIFO_DEPTH transfers
        imem_ack = 1'b1; imem_rdata = 32'h55AA_0000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        xfers = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req && imem_ack) xfers++;
        end
        chk("fill_xfers", 0, 32'(xfers),       32'd4);
        chk("fill_req",   0, 32'(imem_req),    32'h0);
        chk("fill_vld",   0, 32'(instr_valid), 32'h1);
        chk("fill_pc",    0, instr_pc,         32'h0);
        chk("fill_instr", 0, instr,            32'h55AA_0000);

        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        chk("pop_req",  0, 32'(imem_req), 32'h1);
        chk("pop_addr", 0, imem_addr,     32'h10);
        chk("pop_pc",   0, instr_pc,      32'h4);
        @(posedge clk);
        #1;
        chk("refill_req", 0, 32'(imem_req), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
